// File: rtl/ex_pkg.sv
// Shared definitions for the Mipu execute stage: opcodes, CPU state and multiplier FSM states.
package ex_pkg;

  localparam logic [4:0] OP_NOP   = 5'b00000;
  localparam logic [4:0] OP_HALT  = 5'b00001;
  localparam logic [4:0] OP_LOAD  = 5'b00010;
  localparam logic [4:0] OP_STORE = 5'b00011;
  localparam logic [4:0] OP_SLL   = 5'b00100;
  localparam logic [4:0] OP_SLA   = 5'b00101;
  localparam logic [4:0] OP_SRL   = 5'b00110;
  localparam logic [4:0] OP_SRA   = 5'b00111;
  localparam logic [4:0] OP_ADD   = 5'b01000;
  localparam logic [4:0] OP_ADDI  = 5'b01001;
  localparam logic [4:0] OP_SUB   = 5'b01010;
  localparam logic [4:0] OP_SUBI  = 5'b01011;
  localparam logic [4:0] OP_CMP   = 5'b01100;
  localparam logic [4:0] OP_AND   = 5'b01101;
  localparam logic [4:0] OP_OR    = 5'b01110;
  localparam logic [4:0] OP_XOR   = 5'b01111;
  localparam logic [4:0] OP_LDIH  = 5'b10000;
  localparam logic [4:0] OP_ADDC  = 5'b10001;
  localparam logic [4:0] OP_SUBC  = 5'b10010;
  localparam logic [4:0] OP_MUL   = 5'b10011;
  localparam logic [4:0] OP_JUMP  = 5'b11000;
  localparam logic [4:0] OP_JMPR  = 5'b11001;
  localparam logic [4:0] OP_BZ    = 5'b11010;
  localparam logic [4:0] OP_BNZ   = 5'b11011;
  localparam logic [4:0] OP_BN    = 5'b11100;
  localparam logic [4:0] OP_BNN   = 5'b11101;
  localparam logic [4:0] OP_BC    = 5'b11110;
  localparam logic [4:0] OP_BNC   = 5'b11111;

  localparam logic STATE_EXEC = 1'b1;

  typedef enum logic [1:0] {
    MUL_IDLE,
    MUL_BUSY,
    MUL_DONE
  } mul_state_t;

  function automatic logic sets_flags(input logic [4:0] op);
    return op inside {OP_LDIH, OP_ADD, OP_ADDI, OP_ADDC, OP_SUB, OP_SUBI, OP_SUBC, OP_CMP};
  endfunction

endpackage

// File: rtl/ex_alu.sv
// Single-cycle Mipu ALU, DATA_W wide; result and carry-out are purely combinational.
module ex_alu
  import ex_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [4:0]        op,
  input  logic [7:0]        imm,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  input  logic              ci,
  output logic [DATA_W-1:0] y,
  output logic              co
);

  logic [DATA_W:0]   sum;
  logic              use_sum;
  logic [DATA_W-1:0] imm8;
  logic [DATA_W-1:0] imm4;
  logic [3:0]        sh;

  assign imm8 = DATA_W'(imm);
  assign imm4 = DATA_W'(imm[3:0]);
  assign sh   = imm[3:0];

  // Subtractions keep the borrow in sum[DATA_W], which becomes the carry flag.
  always_comb begin
    sum     = '0;
    use_sum = 1'b0;
    y       = c;
    co      = 1'b0;
    case (op)
      OP_ADD:  begin sum = {1'b0, a} + {1'b0, b};                          use_sum = 1'b1; end
      OP_ADDI: begin sum = {1'b0, a} + {1'b0, imm8};                       use_sum = 1'b1; end
      OP_ADDC: begin sum = {1'b0, a} + {1'b0, b} + (DATA_W+1)'(ci);        use_sum = 1'b1; end
      OP_SUB:  begin sum = {1'b0, a} - {1'b0, b};                          use_sum = 1'b1; end
      OP_CMP:  begin sum = {1'b0, a} - {1'b0, b};                          use_sum = 1'b1; end
      OP_SUBI: begin sum = {1'b0, a} - {1'b0, imm8};                       use_sum = 1'b1; end
      OP_SUBC: begin sum = {1'b0, a} - {1'b0, b} - (DATA_W+1)'(ci);        use_sum = 1'b1; end
      OP_LDIH: begin sum = {1'b0, a} + {1'b0, imm8 << 8};                  use_sum = 1'b1; end
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_SLL,
      OP_SLA:  y = a << sh;
      OP_SRL:  y = a >> sh;
      OP_SRA:  y = $unsigned($signed(a) >>> sh);
      OP_LOAD,
      OP_STORE: y = b + imm4;
      OP_JUMP: y = imm8;
      OP_JMPR, OP_BZ, OP_BNZ, OP_BN, OP_BNN, OP_BC, OP_BNC: y = a + imm8;
      default: y = c;
    endcase
    if (use_sum) begin
      y  = sum[DATA_W-1:0];
      co = sum[DATA_W];
    end
  end

endmodule

// File: rtl/ex_mul.sv
// Iterative LSB-first shift-add unsigned multiplier; advances only while hold is low.
module ex_mul
  import ex_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  hold,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic                  busy,
  output logic                  done,
  output logic [2*DATA_W-1:0]   product
);

  localparam int CW = $clog2(DATA_W);

  mul_state_t          st;
  logic [2*DATA_W-1:0] mcand;
  logic [2*DATA_W-1:0] acc;
  logic [DATA_W-1:0]   mplier;
  logic [CW-1:0]       cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      st     <= MUL_IDLE;
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (!hold) begin
      case (st)
        MUL_IDLE: begin
          if (start && !abort) begin
            mcand  <= (2*DATA_W)'(a);
            mplier <= b;
            acc    <= '0;
            cnt    <= CW'(DATA_W - 1);
            st     <= MUL_BUSY;
          end
        end
        MUL_BUSY: begin
          if (abort) begin
            st <= MUL_IDLE;
          end else begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            if (cnt == '0) st <= MUL_DONE;
            else           cnt <= cnt - CW'(1);
          end
        end
        MUL_DONE: st <= MUL_IDLE;
        default:  st <= MUL_IDLE;
      endcase
    end
  end

  assign busy    = (st == MUL_BUSY);
  assign done    = (st == MUL_DONE);
  assign product = acc;

endmodule

// File: rtl/ex_stage_p.sv
// Mipu execute stage (ALU, flags, store forwarding, jump squash).
// Define EX_MUL_EN to build in the iterative MUL unit, reg_H and stall generation.
module ex_stage_p
  import ex_pkg::*;
#(
  parameter int          DATA_W    = 16,
  parameter logic [15:0] SQUASH_IR = 16'h0000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              state,
  input  logic [15:0]       ex_ir,
  input  logic [DATA_W-1:0] reg_A,
  input  logic [DATA_W-1:0] reg_B,
  input  logic [DATA_W-1:0] smdr,
  input  logic              jump,
  output logic [DATA_W-1:0] ALUo,
  output logic [15:0]       mem_ir,
  output logic [DATA_W-1:0] reg_C,
  output logic [DATA_W-1:0] reg_H,
  output logic              zf,
  output logic              nf,
  output logic              cf,
  output logic              dw,
  output logic [DATA_W-1:0] smdr1,
  output logic              stall
);

  logic [4:0] op;
  logic       alu_co;

  assign op = ex_ir[15:11];

  ex_alu #(.DATA_W(DATA_W)) u_alu (
    .op  (op),
    .imm (ex_ir[7:0]),
    .a   (reg_A),
    .b   (reg_B),
    .c   (reg_C),
    .ci  (cf),
    .y   (ALUo),
    .co  (alu_co)
  );

`ifdef EX_MUL_EN
  logic                mul_busy;
  logic                mul_done;
  logic [2*DATA_W-1:0] product;

  ex_mul #(.DATA_W(DATA_W)) u_mul (
    .clock   (clock),
    .reset   (reset),
    .start   (op == OP_MUL),
    .abort   (jump),
    .hold    (state != STATE_EXEC),
    .a       (reg_A),
    .b       (reg_B),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (product)
  );

  // The issue cycle stalls combinationally, before the FSM has left IDLE.
  assign stall = mul_busy || (!mul_done && op == OP_MUL && !jump);
`else
  assign stall = 1'b0;
  assign reg_H = '0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      mem_ir <= SQUASH_IR;
      reg_C  <= '0;
      smdr1  <= '0;
      dw     <= 1'b0;
      zf     <= 1'b0;
      nf     <= 1'b0;
      cf     <= 1'b0;
`ifdef EX_MUL_EN
      reg_H  <= '0;
`endif
    end else if (state == STATE_EXEC) begin
      if (jump) begin
        mem_ir <= SQUASH_IR;
        dw     <= 1'b0;
        smdr1  <= '0;
      end
`ifdef EX_MUL_EN
      else if (mul_done) begin
        mem_ir <= ex_ir;
        reg_C  <= product[DATA_W-1:0];
        reg_H  <= product[2*DATA_W-1:DATA_W];
        zf     <= (product == '0);
        nf     <= product[2*DATA_W-1];
        dw     <= 1'b0;
        smdr1  <= '0;
      end else if (stall) begin
        mem_ir <= SQUASH_IR;
        dw     <= 1'b0;
        smdr1  <= '0;
      end
`else
      else if (op == OP_MUL) begin
        mem_ir <= SQUASH_IR;
      end
`endif
      else begin
        mem_ir <= ex_ir;
        reg_C  <= ALUo;
        if (sets_flags(op)) begin
          zf <= (ALUo == '0);
          nf <= ALUo[DATA_W-1];
          cf <= alu_co;
        end
        if (op == OP_STORE) begin
          dw    <= 1'b1;
          smdr1 <= smdr;
        end else begin
          dw    <= 1'b0;
          smdr1 <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ex_stage_p.sv
// Scoreboard bench for ex_stage_p (DATA_W=16); MUL checks follow the EX_MUL_EN build option.
module tb_ex_stage_p;

  localparam logic [15:0] I_NOP   = 16'h0000;
  localparam logic [15:0] I_STORE = 16'h1800;
  localparam logic [15:0] I_ADD   = 16'h4000;
  localparam logic [15:0] I_SUB   = 16'h5000;
  localparam logic [15:0] I_ADDC  = 16'h8800;
  localparam logic [15:0] I_MUL   = 16'h9800;

  logic        clock, reset, state, jump;
  logic [15:0] ex_ir, reg_A, reg_B, smdr;
  logic [15:0] ALUo, mem_ir, reg_C, reg_H, smdr1;
  logic        zf, nf, cf, dw, stall;

  ex_stage_p #(.DATA_W(16), .SQUASH_IR(16'h0000)) dut (
    .clock(clock), .reset(reset), .state(state), .ex_ir(ex_ir),
    .reg_A(reg_A), .reg_B(reg_B), .smdr(smdr), .jump(jump),
    .ALUo(ALUo), .mem_ir(mem_ir), .reg_C(reg_C), .reg_H(reg_H),
    .zf(zf), .nf(nf), .cf(cf), .dw(dw), .smdr1(smdr1), .stall(stall)
  );

  typedef struct packed {
    logic [15:0] mem_ir, reg_C, reg_H, smdr1;
    logic        zf, nf, cf, dw, stall;
  } exp_t;

  typedef struct {
    int   due;
    int   kind;
    exp_t e;
  } item_t;

  item_t q[$];
  exp_t  e;
  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: compares every queued expectation once its cycle is reached.
  always @(negedge clock) begin
    item_t it;
    while (q.size() > 0 && q[0].due <= cyc) begin
      it = q.pop_front();
      if (it.kind == 1) begin
        chk("stall", 16'(stall), 16'(it.e.stall));
      end else begin
        chk("mem_ir", mem_ir, it.e.mem_ir);
        chk("reg_C",  reg_C,  it.e.reg_C);
        chk("reg_H",  reg_H,  it.e.reg_H);
        chk("smdr1",  smdr1,  it.e.smdr1);
        chk("zf", 16'(zf), 16'(it.e.zf));
        chk("nf", 16'(nf), 16'(it.e.nf));
        chk("cf", 16'(cf), 16'(it.e.cf));
        chk("dw", 16'(dw), 16'(it.e.dw));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [15:0] ir, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] sm, input logic j, input logic st);
    ex_ir = ir; reg_A = a; reg_B = b; smdr = sm; jump = j; state = st;
  endtask

  task automatic push_stall(input logic s);
    item_t it;
    it.due = cyc; it.kind = 1; it.e = e; it.e.stall = s;
    q.push_back(it);
  endtask

  task automatic push_regs(input int lag);
    item_t it;
    it.due = cyc + lag; it.kind = 0; it.e = e;
    q.push_back(it);
  endtask

`ifdef EX_MUL_EN
  // Issue cycle plus nbusy BUSY cycles; one non-exec cycle inserted after busy cycle 'stretch_at'.
  task automatic mul_issue_busy(input logic [15:0] a, input logic [15:0] b, input int nbusy, input int stretch_at);
    drive(I_MUL, a, b, 16'h0, 1'b0, 1'b1);
    push_stall(1'b1);
    e.mem_ir = 16'h0000; e.dw = 1'b0; e.smdr1 = 16'h0;
    push_regs(1);
    tick();
    for (int i = 1; i <= nbusy; i++) begin
      drive(I_MUL, a, b, 16'h0, 1'b0, 1'b1);
      push_stall(1'b1);
      push_regs(1);
      tick();
      if (i == stretch_at) begin
        drive(I_MUL, a, b, 16'h0, 1'b0, 1'b0);
        push_stall(1'b1);
        push_regs(1);
        tick();
      end
    end
  endtask

  task automatic run_mul(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] lo, input logic [15:0] hi, input logic n, input logic z);
    mul_issue_busy(a, b, 16, 7);
    drive(I_MUL, a, b, 16'h0, 1'b0, 1'b1);
    push_stall(1'b0);
    e.mem_ir = I_MUL; e.reg_C = lo; e.reg_H = hi; e.nf = n; e.zf = z; e.dw = 1'b0; e.smdr1 = 16'h0;
    push_regs(1);
    tick();
  endtask
`endif

  initial begin
    e = '0;
    drive(I_NOP, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    push_stall(1'b0);
    push_regs(0);
    tick();

    drive(I_ADD, 16'h7FFF, 16'h0001, 16'h0, 1'b0, 1'b1);
    push_stall(1'b0);
    e.mem_ir = I_ADD; e.reg_C = 16'h8000; e.zf = 1'b0; e.nf = 1'b1; e.cf = 1'b0;
    push_regs(1); tick();

    drive(I_SUB, 16'h1234, 16'h1234, 16'h0, 1'b0, 1'b1);
    push_stall(1'b0);
    e.mem_ir = I_SUB; e.reg_C = 16'h0000; e.zf = 1'b1; e.nf = 1'b0; e.cf = 1'b0;
    push_regs(1); tick();

    drive(I_STORE, 16'h0000, 16'h0010, 16'hBEEF, 1'b0, 1'b1);
    push_stall(1'b0);
    e.mem_ir = I_STORE; e.reg_C = 16'h0010; e.dw = 1'b1; e.smdr1 = 16'hBEEF;
    push_regs(1); tick();

    drive(I_ADD, 16'h0001, 16'h0002, 16'h1111, 1'b0, 1'b1);
    push_stall(1'b0);
    e.mem_ir = I_ADD; e.reg_C = 16'h0003; e.zf = 1'b0; e.dw = 1'b0; e.smdr1 = 16'h0;
    push_regs(1); tick();

    drive(I_ADD, 16'h0005, 16'h0005, 16'h2222, 1'b1, 1'b1);
    push_stall(1'b0);
    e.mem_ir = 16'h0000;
    push_regs(1); tick();

    drive(I_ADD, 16'h0009, 16'h0009, 16'h3333, 1'b0, 1'b0);
    push_stall(1'b0);
    push_regs(1); tick();

    drive(I_ADD, 16'hFFFF, 16'h0002, 16'h0, 1'b0, 1'b1);
    push_stall(1'b0);
    e.mem_ir = I_ADD; e.reg_C = 16'h0001; e.cf = 1'b1;
    push_regs(1); tick();

    drive(I_ADDC, 16'h0001, 16'h0001, 16'h0, 1'b0, 1'b1);
    push_stall(1'b0);
    e.mem_ir = I_ADDC; e.reg_C = 16'h0003; e.cf = 1'b0;
    push_regs(1); tick();

`ifdef EX_MUL_EN
    run_mul(16'h00FF, 16'h0101, 16'hFFFF, 16'h0000, 1'b0, 1'b0);
    run_mul(16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b1, 1'b0);

    mul_issue_busy(16'h0003, 16'h0005, 4, 0);
    drive(I_MUL, 16'h0003, 16'h0005, 16'h0, 1'b1, 1'b1);
    push_stall(1'b1);
    push_regs(1); tick();
    drive(I_NOP, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1);
    push_stall(1'b0);
    e.mem_ir = I_NOP;
    push_regs(1); tick();

    mul_issue_busy(16'h0003, 16'h0005, 4, 0);
    drive(I_MUL, 16'h0003, 16'h0005, 16'h0, 1'b0, 1'b1);
    reset = 1'b1;
    push_stall(1'b1);
    e = '0;
    push_regs(1); tick();
    reset = 1'b0;
    drive(I_NOP, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1);
    push_stall(1'b0);
    push_regs(1); tick();

    run_mul(16'h0003, 16'h0005, 16'h000F, 16'h0000, 1'b0, 1'b0);
`else
    drive(I_STORE, 16'h0000, 16'h0010, 16'hBEEF, 1'b0, 1'b1);
    push_stall(1'b0);
    e.mem_ir = I_STORE; e.reg_C = 16'h0010; e.dw = 1'b1; e.smdr1 = 16'hBEEF;
    push_regs(1); tick();

    drive(I_MUL, 16'hFFFF, 16'hFFFF, 16'h0, 1'b0, 1'b1);
    push_stall(1'b0);
    e.mem_ir = 16'h0000;
    push_regs(1); tick();

    drive(I_ADD, 16'h0001, 16'h0002, 16'h0, 1'b0, 1'b1);
    push_stall(1'b0);
    e.mem_ir = I_ADD; e.reg_C = 16'h0003; e.dw = 1'b0; e.smdr1 = 16'h0;
    push_regs(1); tick();
`endif

    drive(I_NOP, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    tick(); tick();
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_stage_p.md
# ex_stage_p

Parametrised execute stage for the Mipu pipeline, sitting between ID and MEM. It keeps the existing single-cycle ALU path, flag update, store forwarding and jump squash, but widens the datapath to `DATA_W`. It adds an optional iterative unsigned multiplier (`MUL`) that stalls the front end while it runs and writes a double-width product.

## Interface
Parameters:
- `DATA_W`, 16: datapath width for operands, `reg_C`, `reg_H`, `smdr`, `smdr1` and `ALUo`. Minimum 8.
- `SQUASH_IR`, 16'h0000: instruction word written into `mem_ir` for a bubble (jump squash or multiplier stall).

Ports (one clock; reset is synchronous and active-high):
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `state`  in  1  CPU state; the stage advances only when `state == STATE_EXEC`.
- `ex_ir`  in  16  instruction in EX; opcode is `ex_ir[15:11]`.
- `reg_A`, `reg_B`  in  DATA_W  operands from ID.
- `smdr`  in  DATA_W  store data from ID.
- `jump`  in  1  squash request for the instruction currently in EX.
- `ALUo`  out  DATA_W  combinational ALU result.
- `mem_ir`  out  16  instruction passed to MEM.
- `reg_C`  out  DATA_W  registered ALU result, or the low half of the product.
- `reg_H`  out  DATA_W  high half of the last `MUL` product.
- `zf`, `nf`, `cf`  out  1  condition flags.
- `dw`  out  1  data-memory write enable for MEM.
- `smdr1`  out  DATA_W  store data for MEM.
- `stall`  out  1  combinational; while high, IF/ID must hold, and `ex_ir`/`reg_A`/`reg_B` must stay stable.

## Operation
- Reset, synchronous on the rising edge of `clock` with `reset` high:
  - `mem_ir`=`SQUASH_IR`.
  - `reg_C`=`reg_H`=`smdr1`=0.
  - `dw`=`zf`=`nf`=`cf`=0.
  - Multiplier FSM goes to IDLE, so `stall`=0.
- `state != STATE_EXEC`: all registers hold, including the multiplier FSM and its counter. `stall` keeps its FSM-derived value.
- `jump`=1 in exec has top priority:
  - `mem_ir`←`SQUASH_IR`; `dw`←0; `smdr1`←0.
  - `reg_C`, `reg_H` and the flags hold.
  - A multiplier in BUSY or DONE aborts to IDLE and writes nothing.
- Non-MUL instruction in exec, no jump:
  - `mem_ir`←`ex_ir`; `reg_C`←`ALUo`.
  - For LDIH, ADD, ADDI, ADDC, SUB, SUBI, SUBC, CMP: `zf`←(`ALUo`==0), `nf`←`ALUo[DATA_W-1]`, `cf`←ALU carry-out. Other opcodes leave the flags unchanged.
  - STORE: `dw`←1 and `smdr1`←`smdr`. Any other opcode: `dw`←0 and `smdr1`←0.
- ALU carry-in is `cf`. ALU feedback input is `reg_C`.
- Multiplier FSM, states IDLE, BUSY, DONE:
  - IDLE with `MUL` in exec and no jump:
    - Latch `reg_A` (multiplicand) and `reg_B` (multiplier).
    - Clear the 2·`DATA_W` accumulator.
    - Set `cnt`=`DATA_W`-1, go to BUSY.
    - `stall`=1; `mem_ir`←`SQUASH_IR`.
  - BUSY: one shift-add step per exec cycle, LSB-first. `stall`=1; `mem_ir`←`SQUASH_IR`. When `cnt`==0, go to DONE; otherwise decrement `cnt`.
  - DONE: `stall`=0.
    - `mem_ir`←`ex_ir`; `reg_C`←product[DATA_W-1:0]; `reg_H`←product[2·DATA_W-1:DATA_W].
    - `zf`←(product==0); `nf`←product[2·DATA_W-1]; `cf` unchanged.
    - `dw`←0. Go to IDLE.
- Arithmetic is unsigned modulo 2^(2·DATA_W); the product never overflows.

## Timing
- ALU path: result is visible in `reg_C`/`mem_ir` one edge after issue. `ALUo` is combinational from the EX inputs.
- `MUL` issued in exec cycle T:
  - `stall` is high in cycles T through T+`DATA_W`.
  - DONE is cycle T+`DATA_W`+1; results are visible after the edge that ends it.
  - Total occupancy is `DATA_W`+2 exec cycles.
- Non-exec cycles stretch the sequence without losing state.
- Back-to-back `MUL`: the second one issues from IDLE in the cycle after DONE.
- `reset` mid-multiply: abort immediately, no writes, `stall`=0 in the next cycle.

## Configuration
- `EX_MUL_EN` defined: multiplier FSM, `reg_H` logic and `stall` generation are compiled in.
- `EX_MUL_EN` undefined:
  - `MUL` is treated as illegal: `mem_ir`←`SQUASH_IR`, flags, `reg_C` and `dw` are unchanged.
  - `stall` is tied to 0; `reg_H` is tied to 0.

## Structure
- Shared package `ex_pkg`:
  - 5-bit opcode constants, including new `MUL`.
  - `STATE_EXEC`.
  - Multiplier FSM enum (IDLE/BUSY/DONE).
- Sub-module `ex_mul`, parametrised by `DATA_W`:
  - Iterative shift-add multiplier with `start`, `abort`, `hold`, `busy`, `done`, `product`.
  - Instantiated only under `EX_MUL_EN`.
- The existing ALU is instantiated with `DATA_W`.

## Test plan
1. Reset held 2 cycles, then released → all outputs 0, `mem_ir`=16'h0000, `stall`=0.
2. ADD with A=16'h7FFF, B=16'h0001 → `reg_C`=16'h8000, `nf`=1, `zf`=0, `cf`=0. Then SUB with A=B=16'h1234 → `zf`=1.
3. STORE with `smdr`=16'hBEEF → `dw`=1, `smdr1`=16'hBEEF, `mem_ir`=STORE. Following ADD → `dw`=0, `smdr1`=0.
4. `jump`=1 with ADD in EX → `mem_ir`=`SQUASH_IR`, `reg_C` and flags unchanged.
5. MUL with A=B=16'hFFFF, DATA_W=16:
   - `stall` high 17 cycles.
   - Then `reg_H`=16'hFFFE, `reg_C`=16'h0001, `nf`=1, `zf`=0, `mem_ir`=MUL.
   - Repeat with A=16'h00FF, B=16'h0101 → `reg_C`=16'hFFFF, `reg_H`=0, `nf`=0.
6. MUL with `jump` pulsed in BUSY cycle 5 → FSM returns to IDLE, `stall`=0 next cycle, `reg_C`/`reg_H` unchanged. Repeat with `reset` pulsed instead → full reset values.
